// File: rtl/pwm_d2a_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_d2a_pkg
// Description : Shared types and helpers for the PWM D2A converter.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_d2a_pkg;

    // Control state of the converter
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;

    // Period counter needs to represent 0..N_PRD (one extra bit of headroom)
    function automatic int prd_cnt_width(input int n_prd);
        return $clog2(n_prd) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_ramp_cnt.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_cnt
// Description : Free-running WIDTH-bit ramp counter with synchronous clear,
//               count enable and a terminal-count (all ones) flag.
//               Clear has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_cnt #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise increment with natural wrap
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == {WIDTH{1'b1}});

endmodule
`default_nettype wire

// File: rtl/pwm_d2a.sv
`default_nettype none
// ============================================================================
// Module      : pwm_d2a
// Description : PWM digital-to-analog converter. A captured code is compared
//               against a free-running ramp; each conversion emits N_PRD full
//               PWM periods and then pulses cnv_cmplt for one cycle.
//               Optional macro PWM_DBL_BUF_EN adds a pending-code buffer so a
//               start request during RUN chains the next conversion without
//               an idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_d2a
    import pwm_d2a_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int N_PRD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt_cnv,
    input  logic [WIDTH-1:0] code,
    output logic             pwm_out,
    output logic             busy,
    output logic             cnv_cmplt
);

    localparam int             PW       = prd_cnt_width(N_PRD);
    localparam logic [PW-1:0]  PRD_LAST = PW'(N_PRD - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] code_reg_q;
    logic [WIDTH-1:0] code_reg_d;
    logic [PW-1:0]    prd_cnt_q;
    logic [PW-1:0]    prd_cnt_d;
    logic             pwm_q;
    logic             pwm_d;
    logic             cmplt_q;
    logic             cmplt_d;

    logic [WIDTH-1:0] cnt;
    logic             cnt_wrap;
    logic             cnt_clr;
    logic             cnt_en;
    logic             end_cnv;
    logic             restart;

    pwm_ramp_cnt #(
        .WIDTH (WIDTH)
    ) u_ramp (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .wrap_o (cnt_wrap)
    );

    // Last cycle of the last period of the conversion
    assign end_cnv = (state_q == RUN) && cnt_wrap && (prd_cnt_q == PRD_LAST);

`ifdef PWM_DBL_BUF_EN
    logic             pend_vld_q;
    logic             pend_vld_d;
    logic [WIDTH-1:0] pend_code_q;
    logic [WIDTH-1:0] pend_code_d;

    // A live start request on the final cycle beats the buffered one
    assign restart = end_cnv && (strt_cnv || pend_vld_q);

    // Capture start requests that arrive while a conversion is running
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        if (restart) begin
            pend_vld_d = 1'b0;
        end else if ((state_q == RUN) && !end_cnv && strt_cnv) begin
            pend_vld_d  = 1'b1;
            pend_code_d = code;
        end
    end

    // Pending-code buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q  <= 1'b0;
            pend_code_q <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
        end
    end
`else
    assign restart = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unknown encodings fall back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (end_cnv && !restart) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls and next values of the registered outputs
    always_comb begin
        pwm_d      = 1'b0;
        cmplt_d    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        code_reg_d = code_reg_q;
        prd_cnt_d  = prd_cnt_q;
        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    cnt_clr    = 1'b1;
                    code_reg_d = code;
                    prd_cnt_d  = '0;
                end
            end
            RUN: begin
                cnt_en  = 1'b1;
                pwm_d   = end_cnv ? 1'b0 : (cnt < code_reg_q);
                cmplt_d = end_cnv;
                if (cnt_wrap) begin
                    prd_cnt_d = prd_cnt_q + PW'(1);
                end
`ifdef PWM_DBL_BUF_EN
                if (restart) begin
                    cnt_clr    = 1'b1;
                    prd_cnt_d  = '0;
                    code_reg_d = strt_cnv ? code : pend_code_q;
                end
`endif
            end
            default: begin
                pwm_d   = 1'b0;
                cmplt_d = 1'b0;
            end
        endcase
    end

    // Code, period counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_reg_q <= '0;
            prd_cnt_q  <= '0;
            pwm_q      <= 1'b0;
            cmplt_q    <= 1'b0;
        end else begin
            code_reg_q <= code_reg_d;
            prd_cnt_q  <= prd_cnt_d;
            pwm_q      <= pwm_d;
            cmplt_q    <= cmplt_d;
        end
    end

    assign pwm_out   = pwm_q;
    assign cnv_cmplt = cmplt_q;
    assign busy      = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_pwm_d2a.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_d2a
// Description : Self-checking bench for pwm_d2a (WIDTH=4, N_PRD=2). A
//               cycle-level reference tracks elapsed RUN cycles per
//               conversion; directed scenarios also check duty and timing
//               totals. Honours PWM_DBL_BUF_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_d2a;

    localparam int W     = 4;
    localparam int NP    = 2;
    localparam int P     = 16;
    localparam int TOTAL = NP * P;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         strt_cnv = 1'b0;
    logic [W-1:0] code = '0;
    logic         pwm_out;
    logic         busy;
    logic         cnv_cmplt;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    pwm_d2a #(
        .WIDTH (W),
        .N_PRD (NP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .code      (code),
        .pwm_out   (pwm_out),
        .busy      (busy),
        .cnv_cmplt (cnv_cmplt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_k = number of RUN edges already taken in the current conversion
    bit m_run   = 1'b0;
    bit m_pwm   = 1'b0;
    bit m_cmplt = 1'b0;
    int m_code  = 0;
    int m_k     = 0;
    bit m_pend_v = 1'b0;
    int m_pend_c = 0;
    bit m_last;
    assign m_last = m_run && (m_k == TOTAL - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run    <= 1'b0;
            m_pwm    <= 1'b0;
            m_cmplt  <= 1'b0;
            m_code   <= 0;
            m_k      <= 0;
            m_pend_v <= 1'b0;
            m_pend_c <= 0;
        end else if (!m_run) begin
            m_pwm   <= 1'b0;
            m_cmplt <= 1'b0;
            if (strt_cnv) begin
                m_run  <= 1'b1;
                m_code <= int'(code);
                m_k    <= 0;
            end
        end else if (m_last) begin
            m_pwm   <= 1'b0;
            m_cmplt <= 1'b1;
`ifdef PWM_DBL_BUF_EN
            if (strt_cnv) begin
                m_code   <= int'(code);
                m_k      <= 0;
                m_pend_v <= 1'b0;
            end else if (m_pend_v) begin
                m_code   <= m_pend_c;
                m_k      <= 0;
                m_pend_v <= 1'b0;
            end else begin
                m_run <= 1'b0;
            end
`else
            m_run <= 1'b0;
`endif
        end else begin
            m_pwm   <= ((m_k % P) < m_code);
            m_cmplt <= 1'b0;
            m_k     <= m_k + 1;
`ifdef PWM_DBL_BUF_EN
            if (strt_cnv) begin
                m_pend_v <= 1'b1;
                m_pend_c <= int'(code);
            end
`endif
        end
    end

    // Cycle-by-cycle comparison against the reference
    always @(negedge clk) begin
        if (mon_en) begin
            chk("pwm_out",   int'(pwm_out),   int'(m_pwm));
            chk("busy",      int'(busy),      int'(m_run));
            chk("cnv_cmplt", int'(cnv_cmplt), int'(m_cmplt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_conv(input logic [W-1:0] c);
        @(negedge clk);
        strt_cnv = 1'b1;
        code     = c;
        @(posedge clk);
        #1;
        strt_cnv = 1'b0;
        code     = W'($urandom);
    endtask

    // Sample n cycles (sample 1 = first cycle after the start edge)
    task automatic observe(input int n, input int inj_at, input logic [W-1:0] inj_code,
                           output int busy_n, output int hi_n, output int cm_n,
                           output int first_cm, output int cm_busy);
        busy_n = 0; hi_n = 0; cm_n = 0; first_cm = 0; cm_busy = 0;
        for (int s = 1; s <= n; s++) begin
            @(negedge clk);
            busy_n += int'(busy);
            hi_n   += int'(pwm_out);
            if (cnv_cmplt) begin
                cm_n++;
                if (first_cm == 0) first_cm = s;
                if (busy) cm_busy++;
            end
            if (inj_at != 0 && s == inj_at) begin
                strt_cnv = 1'b1;
                code     = inj_code;
            end else if (inj_at != 0 && s == inj_at + 1) begin
                strt_cnv = 1'b0;
                code     = W'($urandom);
            end
        end
    endtask

    int b, h, cm, f, cb;
    logic [W-1:0] rc, ic;
    int inj;

    initial begin
        // 1. reset
        #12;
        chk("rst_pwm",   int'(pwm_out),   0);
        chk("rst_busy",  int'(busy),      0);
        chk("rst_cmplt", int'(cnv_cmplt), 0);
        mon_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        observe(20, 0, '0, b, h, cm, f, cb);
        chk("idle_busy", b, 0);
        chk("idle_hi", h, 0);
        chk("idle_cmplt", cm, 0);

        // 2. code=5 conversion
        start_conv(4'd5);
        observe(40, 0, '0, b, h, cm, f, cb);
        chk("c5_busy", b, TOTAL);
        chk("c5_hi", h, 2 * 5);
        chk("c5_cmplt_n", cm, 1);
        chk("c5_cmplt_at", f, TOTAL + 1);
        chk("c5_cmplt_busy", cb, 0);

        // 3. boundary codes
        start_conv(4'd0);
        observe(40, 0, '0, b, h, cm, f, cb);
        chk("c0_hi", h, 0);
        chk("c0_cmplt_n", cm, 1);
        start_conv(4'd15);
        observe(40, 0, '0, b, h, cm, f, cb);
        chk("c15_hi", h, 2 * 15);
        chk("c15_cmplt_n", cm, 1);
        chk("c15_busy", b, TOTAL);

        // 4. start request at cycle 10 of a code=5 conversion
        start_conv(4'd5);
        observe(70, 10, 4'd9, b, h, cm, f, cb);
`ifdef PWM_DBL_BUF_EN
        chk("dbl_busy", b, 2 * TOTAL);
        chk("dbl_hi", h, 2 * 5 + 2 * 9);
        chk("dbl_cmplt_n", cm, 2);
`else
        chk("ign_busy", b, TOTAL);
        chk("ign_hi", h, 2 * 5);
        chk("ign_cmplt_n", cm, 1);
`endif

        // 5. reset mid-conversion
        start_conv(4'd5);
        observe(19, 0, '0, b, h, cm, f, cb);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pwm",   int'(pwm_out),   0);
        chk("arst_busy",  int'(busy),      0);
        chk("arst_cmplt", int'(cnv_cmplt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        observe(10, 0, '0, b, h, cm, f, cb);
        chk("post_rst_cmplt", cm, 0);
        chk("post_rst_busy", b, 0);
        start_conv(4'd5);
        observe(40, 0, '0, b, h, cm, f, cb);
        chk("restart_busy", b, TOTAL);
        chk("restart_hi", h, 2 * 5);
        chk("restart_cmplt_at", f, TOTAL + 1);

        // 6. strt_cnv held high
        @(negedge clk);
        strt_cnv = 1'b1;
        code     = 4'd3;
        @(posedge clk);
        observe(66, 0, '0, b, h, cm, f, cb);
        strt_cnv = 1'b0;
        chk("held_cmplt_n", cm, 2);
`ifdef PWM_DBL_BUF_EN
        chk("held_busy", b, 66);
`else
        chk("held_busy", b, 2 * TOTAL);
        chk("held_hi", h, 2 * 2 * 3);
        chk("held_cmplt_busy", cb, 0);
`endif
        observe(40, 0, '0, b, h, cm, f, cb);

        // Randomized conversions with optional mid-run start requests
        for (int it = 0; it < 24; it++) begin
            rc  = W'($urandom_range(0, 15));
            ic  = W'($urandom_range(0, 15));
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : 0;
            start_conv(rc);
            observe(70, inj, ic, b, h, cm, f, cb);
`ifdef PWM_DBL_BUF_EN
            chk("rnd_hi", h, 2 * int'(rc) + ((inj != 0) ? 2 * int'(ic) : 0));
            chk("rnd_cmplt_n", cm, (inj != 0) ? 2 : 1);
`else
            chk("rnd_hi", h, 2 * int'(rc));
            chk("rnd_cmplt_n", cm, 1);
`endif
            chk("rnd_cmplt_at", f, TOTAL + 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
